// File: rtl/inst_fetch_unit_if.sv
// Fetch-side bus bundle: instruction-memory request/response
// and the decode-facing valid/ready head of the fetch FIFO.
interface inst_fetch_unit_if #(
    parameter int DATA_W = 32
);
    logic              InstMem_Read;
    logic [DATA_W-1:0] InstMem_Address;
    logic              InstMem_Ready;
    logic [DATA_W-1:0] inst1_in;
    logic [DATA_W-1:0] inst2_in;
    logic              dec_valid;
    logic              dec_ready;
    logic [DATA_W-1:0] dec_PC;
    logic [DATA_W-1:0] dec_inst1;
    logic [DATA_W-1:0] dec_inst2;
    logic              dec_pred_taken;

    modport master (
        output InstMem_Read,
        output InstMem_Address,
        input  InstMem_Ready,
        input  inst1_in,
        input  inst2_in,
        output dec_valid,
        input  dec_ready,
        output dec_PC,
        output dec_inst1,
        output dec_inst2,
        output dec_pred_taken
    );

    modport slave (
        input  InstMem_Read,
        input  InstMem_Address,
        output InstMem_Ready,
        output inst1_in,
        output inst2_in,
        input  dec_valid,
        output dec_ready,
        input  dec_PC,
        input  dec_inst1,
        input  dec_inst2,
        input  dec_pred_taken
    );
endinterface

// File: rtl/inst_fetch_unit.sv
// Dual-issue fetch engine: one outstanding pair request,
// predictor/redirect PC steering, small pair FIFO to decode.
module inst_fetch_unit #(
    parameter int                DATA_W     = 32,
    parameter int                FIFO_DEPTH = 4,
    parameter logic [DATA_W-1:0] RESET_PC   = '0
) (
    input  logic                clk,
    input  logic                rst,
    inst_fetch_unit_if.master   bus,
    input  logic                Inst1_maybe_Branch,
    input  logic                Inst2_maybe_Branch,
    input  logic                Pre_Take,
    input  logic [DATA_W-1:0]   Pre_PC,
    input  logic                Redirect,
    input  logic [DATA_W-1:0]   Redirect_PC
);
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
    localparam logic [DATA_W-1:0] STEP = DATA_W'(8);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        DROP
    } state_e;

    typedef struct packed {
        logic [DATA_W-1:0] pc;
        logic [DATA_W-1:0] i1;
        logic [DATA_W-1:0] i2;
        logic              tk;
    } ent_t;

    state_e            state_q;
    logic              read_q;
    logic [DATA_W-1:0] pc_q;
    logic [DATA_W-1:0] tgt_q;

    ent_t              mem_q [FIFO_DEPTH];
    logic [PW-1:0]     wr_q;
    logic [PW-1:0]     rd_q;
    logic [CW-1:0]     count_q;
    logic [CW-1:0]     count_d;

    logic              xfer;
    logic              taken;
    logic              push;
    logic              pop;
    ent_t              head;
    ent_t              new_ent;

    // Inst2 branches are never predicted; the hint is accepted but unused.
    logic              unused_inst2_br;
    assign unused_inst2_br = Inst2_maybe_Branch;

    assign xfer  = read_q & bus.InstMem_Ready;
    assign taken = Inst1_maybe_Branch & Pre_Take;
    assign push  = (state_q == REQ) & xfer & ~Redirect
                 & (count_q < DEPTH_C);
    assign pop   = (count_q != '0) & bus.dec_ready & ~Redirect;

    assign new_ent.pc = pc_q;
    assign new_ent.i1 = bus.inst1_in;
    assign new_ent.i2 = bus.inst2_in;
    assign new_ent.tk = taken;

    assign head = mem_q[rd_q];

    assign bus.InstMem_Read    = read_q;
    assign bus.InstMem_Address = pc_q;
    assign bus.dec_valid       = (count_q != '0);
    assign bus.dec_PC          = head.pc;
    assign bus.dec_inst1       = head.i1;
    assign bus.dec_inst2       = head.i2;
    assign bus.dec_pred_taken  = head.tk;

    // Occupancy after this edge; a redirect empties the buffer.
    always_comb begin
        count_d = count_q;
        if (Redirect) begin
            count_d = '0;
        end else begin
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    // Pair FIFO storage and pointers; cleared on redirect.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (Redirect) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                mem_q[wr_q] <= new_ent;
                wr_q        <= wr_q + PW'(1);
            end
            if (pop) begin
                rd_q <= rd_q + PW'(1);
            end
            count_q <= count_d;
        end
    end

    // Fetch FSM: owns the request flag, fetch PC and redirect target.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            read_q  <= 1'b0;
            pc_q    <= RESET_PC;
            tgt_q   <= RESET_PC;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (Redirect) begin
                        pc_q    <= Redirect_PC;
                        state_q <= REQ;
                        read_q  <= 1'b1;
                    end else if (count_q < DEPTH_C) begin
                        state_q <= REQ;
                        read_q  <= 1'b1;
                    end
                end
                REQ: begin
                    if (Redirect) begin
                        if (xfer) begin
                            pc_q <= Redirect_PC;
                        end else begin
                            state_q <= DROP;
                            tgt_q   <= Redirect_PC;
                        end
                    end else if (xfer) begin
                        pc_q <= taken ? Pre_PC : pc_q + STEP;
                        if (count_d >= DEPTH_C) begin
                            state_q <= IDLE;
                            read_q  <= 1'b0;
                        end
                    end
                end
                DROP: begin
                    if (xfer) begin
                        state_q <= REQ;
                        pc_q    <= Redirect ? Redirect_PC : tgt_q;
                    end else if (Redirect) begin
                        tgt_q <= Redirect_PC;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    read_q  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_inst_fetch_unit.sv
// Directed bench for inst_fetch_unit: vector table for
// streaming/fill, hand sequences for predict, redirect, reset.
module tb_inst_fetch_unit;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        rdy;
    logic        drdy;
    logic        br_en;
    logic        redir;
    logic [31:0] redir_pc;
    logic        br_hit;

    int checks = 0;
    int passed = 0;

    inst_fetch_unit_if #(.DATA_W(32)) bus ();

    function automatic logic [31:0] word(input logic [31:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    assign bus.InstMem_Ready = bus.InstMem_Read & rdy;
    assign bus.inst1_in      = word(bus.InstMem_Address);
    assign bus.inst2_in      = word(bus.InstMem_Address + 32'd4);
    assign bus.dec_ready     = drdy;
    assign br_hit = br_en & (bus.InstMem_Address == 32'h40);

    inst_fetch_unit #(
        .DATA_W(32),
        .FIFO_DEPTH(4),
        .RESET_PC(32'h0)
    ) dut (
        .clk               (clk),
        .rst               (rst_n),
        .bus               (bus),
        .Inst1_maybe_Branch(br_hit),
        .Inst2_maybe_Branch(1'b0),
        .Pre_Take          (br_hit),
        .Pre_PC            (32'h100),
        .Redirect          (redir),
        .Redirect_PC       (redir_pc)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst_n;
        logic        rdy;
        logic        drdy;
        logic        e_read;
        logic [31:0] e_addr;
        logic        e_dv;
        logic [31:0] e_dpc;
        logic        e_tk;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp)
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        else
            passed++;
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        redir = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic run_to(input logic [31:0] a, input string nm);
        int n;
        n = 0;
        while (bus.InstMem_Address !== a && n < 40) begin
            tick();
            n++;
        end
        chk(nm, bus.InstMem_Address, a);
    endtask

    vec_t tbl [13];

    initial begin
        rst_n = 1'b0; rdy = 1'b0; drdy = 1'b0;
        br_en = 1'b0; redir = 1'b0; redir_pc = '0;

        // streaming with decode always ready
        tbl[0]  = '{0, 1, 1, 0, 32'h00, 0, 32'h00, 0};
        tbl[1]  = '{1, 1, 1, 1, 32'h00, 0, 32'h00, 0};
        tbl[2]  = '{1, 1, 1, 1, 32'h08, 1, 32'h00, 0};
        tbl[3]  = '{1, 1, 1, 1, 32'h10, 1, 32'h08, 0};
        tbl[4]  = '{1, 1, 1, 1, 32'h18, 1, 32'h10, 0};
        tbl[5]  = '{1, 1, 1, 1, 32'h20, 1, 32'h18, 0};
        // fill with decode stalled
        tbl[6]  = '{0, 1, 0, 0, 32'h00, 0, 32'h00, 0};
        tbl[7]  = '{1, 1, 0, 1, 32'h00, 0, 32'h00, 0};
        tbl[8]  = '{1, 1, 0, 1, 32'h08, 1, 32'h00, 0};
        tbl[9]  = '{1, 1, 0, 1, 32'h10, 1, 32'h00, 0};
        tbl[10] = '{1, 1, 0, 1, 32'h18, 1, 32'h00, 0};
        tbl[11] = '{1, 1, 0, 0, 32'h20, 1, 32'h00, 0};
        tbl[12] = '{1, 1, 0, 0, 32'h20, 1, 32'h00, 0};

        @(negedge clk);
        for (int i = 0; i < 13; i++) begin
            rst_n = tbl[i].rst_n;
            rdy   = tbl[i].rdy;
            drdy  = tbl[i].drdy;
            tick();
            chk($sformatf("v%0d_read", i), 32'(bus.InstMem_Read),
                32'(tbl[i].e_read));
            chk($sformatf("v%0d_addr", i), bus.InstMem_Address,
                tbl[i].e_addr);
            chk($sformatf("v%0d_dv", i), 32'(bus.dec_valid),
                32'(tbl[i].e_dv));
            chk($sformatf("v%0d_dpc", i), bus.dec_PC, tbl[i].e_dpc);
            chk($sformatf("v%0d_tk", i), 32'(bus.dec_pred_taken),
                32'(tbl[i].e_tk));
            if (tbl[i].e_dv)
                chk($sformatf("v%0d_i1", i), bus.dec_inst1,
                    word(tbl[i].e_dpc));
            if (!tbl[i].rst_n)
                chk($sformatf("v%0d_rst_i1", i), bus.dec_inst1, 32'h0);
        end

        // single pop from a full FIFO restarts fetch at 0x20
        begin
            int n;
            drdy = 1'b1;
            tick();
            drdy = 1'b0;
            chk("pop_dpc", bus.dec_PC, 32'h08);
            n = 0;
            while (!bus.InstMem_Read && n < 3) begin
                tick();
                n++;
            end
            chk("refill_read", 32'(bus.InstMem_Read), 32'h1);
            chk("refill_addr", bus.InstMem_Address, 32'h20);
        end

        // predicted-taken branch at 0x40
        do_reset();
        rdy = 1'b1; drdy = 1'b1; br_en = 1'b1;
        run_to(32'h40, "br_reach");
        tick();
        chk("br_addr", bus.InstMem_Address, 32'h100);
        chk("br_dpc", bus.dec_PC, 32'h40);
        chk("br_tk", 32'(bus.dec_pred_taken), 32'h1);
        chk("br_i2", bus.dec_inst2, word(32'h44));
        tick();
        chk("br_next_addr", bus.InstMem_Address, 32'h108);
        chk("br_next_dpc", bus.dec_PC, 32'h100);
        chk("br_next_tk", 32'(bus.dec_pred_taken), 32'h0);
        br_en = 1'b0;

        // redirect while the request is stalled
        do_reset();
        rdy = 1'b1; drdy = 1'b1;
        run_to(32'h20, "st_reach");
        rdy = 1'b0;
        tick();
        chk("st_hold1", bus.InstMem_Address, 32'h20);
        redir = 1'b1; redir_pc = 32'h200;
        tick();
        redir = 1'b0;
        chk("st_hold2", bus.InstMem_Address, 32'h20);
        chk("st_read", 32'(bus.InstMem_Read), 32'h1);
        chk("st_dv0", 32'(bus.dec_valid), 32'h0);
        tick();
        chk("st_hold3", bus.InstMem_Address, 32'h20);
        rdy = 1'b1;
        tick();
        chk("st_new_addr", bus.InstMem_Address, 32'h200);
        chk("st_no_push", 32'(bus.dec_valid), 32'h0);
        drdy = 1'b0;
        tick();
        chk("st_first_dpc", bus.dec_PC, 32'h200);
        chk("st_first_dv", 32'(bus.dec_valid), 32'h1);

        // redirect on the same edge as a transfer, two entries held
        do_reset();
        rdy = 1'b1; drdy = 1'b0;
        tick(); tick(); tick();
        chk("sr_pre_addr", bus.InstMem_Address, 32'h10);
        chk("sr_pre_dpc", bus.dec_PC, 32'h00);
        redir = 1'b1; redir_pc = 32'h300; drdy = 1'b1;
        tick();
        redir = 1'b0; drdy = 1'b0;
        chk("sr_dv0", 32'(bus.dec_valid), 32'h0);
        chk("sr_addr", bus.InstMem_Address, 32'h300);
        tick();
        chk("sr_dpc", bus.dec_PC, 32'h300);
        chk("sr_i1", bus.dec_inst1, word(32'h300));

        // asynchronous reset mid-request
        do_reset();
        rdy = 1'b1; drdy = 1'b1;
        run_to(32'h10, "ar_reach");
        rdy = 1'b0;
        tick();
        #2 rst_n = 1'b0;
        #1;
        chk("ar_read", 32'(bus.InstMem_Read), 32'h0);
        chk("ar_addr", bus.InstMem_Address, 32'h0);
        chk("ar_dv", 32'(bus.dec_valid), 32'h0);
        @(negedge clk);
        rst_n = 1'b1; rdy = 1'b1;
        tick();
        chk("ar_rs_read", 32'(bus.InstMem_Read), 32'h1);
        chk("ar_rs_addr", bus.InstMem_Address, 32'h0);
        tick();
        chk("ar_rs_addr2", bus.InstMem_Address, 32'h8);
        chk("ar_rs_dpc", bus.dec_PC, 32'h0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
